// File: rtl/lif_scheduler_if.sv
// Bundled control, write, readback and status signals for lif_scheduler.
// Latency: none; this is a signal bundle only.
// Backpressure: none; step arriving while busy is flagged by the block, not stalled.
interface lif_scheduler_if #(
    parameter int N_NEUR = 4
);
    localparam int AW = $clog2(N_NEUR);

    logic              step;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_state;
    logic              busy;
    logic              done;
    logic [N_NEUR-1:0] spike_vec;
    logic [7:0]        spike_cnt;
    logic              overrun;

    // Driver side: issues timesteps, writes currents, selects readback.
    modport master (
        output step, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_state, busy, done, spike_vec, spike_cnt, overrun
    );

    // Scheduler side.
    modport slave (
        input  step, wr_en, wr_addr, wr_data, rd_addr,
        output rd_state, busy, done, spike_vec, spike_cnt, overrun
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath sweeps N_NEUR neurons per step.
// Latency: step sampled at edge t -> done pulse in cycle t+N_NEUR+1; rd_state is one cycle behind rd_addr.
// Backpressure: none; a step while busy is dropped and raises the sticky overrun flag.
module lif_scheduler #(
    parameter int          N_NEUR = 4,
    parameter logic [7:0]  THRESH = 8'd200
) (
    input  logic           clk,
    input  logic           reset,
    lif_scheduler_if.slave bus
);
    localparam int AW = $clog2(N_NEUR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        cur_q [N_NEUR];
    logic [7:0]        st_q  [N_NEUR];
    logic [N_NEUR-1:0] shadow_q, shadow_d;
    logic [N_NEUR-1:0] spike_vec_q, spike_vec_d;
    logic [7:0]        spike_cnt_q, spike_cnt_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        rd_q;

    logic              busy;
    logic [7:0]        cur_sel;
    logic [7:0]        st_sel;
    logic              sp;
    logic [8:0]        sum9;
    logic [7:0]        st_next;
    logic [4:0]        pop;
    logic [8:0]        cnt_sum;

    assign busy = (state_q != S_IDLE);

    // Shared LIF datapath for the neuron selected by idx; sum is kept in 9 bits and clipped.
    always_comb begin
        cur_sel = cur_q[idx_q];
        st_sel  = st_q[idx_q];
        sp      = (st_sel >= THRESH);
        sum9    = {1'b0, cur_sel} + (sp ? 9'd0 : {2'b00, st_sel[7:1]});
        st_next = sum9[8] ? 8'hFF : sum9[7:0];
    end

    // Spike count of the finished sweep and the saturated running total.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_NEUR; i++) begin
            pop = pop + 5'(shadow_q[i]);
        end
        cnt_sum = {1'b0, spike_cnt_q} + {4'b0000, pop};
    end

    // Next-state logic: sweep sequencing, spike collection, result publication, overrun.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        spike_vec_d = spike_vec_q;
        spike_cnt_d = spike_cnt_q;
        overrun_d   = overrun_q | (bus.step & busy);
        case (state_q)
            S_IDLE: begin
                if (bus.step) begin
                    state_d  = S_UPDATE;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            S_UPDATE: begin
                shadow_d[idx_q] = sp;
                idx_d           = idx_q + AW'(1);
                if (idx_q == AW'(N_NEUR - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                spike_vec_d = shadow_q;
                spike_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers; reset aborts any sweep in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            spike_vec_q <= '0;
            spike_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            spike_vec_q <= spike_vec_d;
            spike_cnt_q <= spike_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    // Input current registers; a write to the neuron being updated lands after the datapath read it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEUR; i++) begin
                cur_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            cur_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Membrane state: only the neuron under update changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEUR; i++) begin
                st_q[i] <= '0;
            end
        end else if (state_q == S_UPDATE) begin
            st_q[idx_q] <= st_next;
        end
    end

    // Registered membrane readback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= st_q[bus.rd_addr];
        end
    end

    assign bus.rd_state  = rd_q;
    assign bus.busy      = busy;
    assign bus.done      = (state_q == S_DONE);
    assign bus.spike_vec = spike_vec_q;
    assign bus.spike_cnt = spike_cnt_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Every wait on the DUT is bounded by a cycle budget and a global time limit.
module tb_lif_scheduler;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   done_cnt;
    int   d0;
    int   exp_st  [4] = '{120, 180, 210, 120};
    int   exp_sv  [4] = '{0, 0, 0, 1};
    int   exp_cnt [4] = '{0, 0, 0, 1};

    lif_scheduler_if #(.N_NEUR(N)) ifc ();

    lif_scheduler #(.N_NEUR(N), .THRESH(8'd200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wr(input int a, input int d);
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 2'(a);
        ifc.wr_data = 8'(d);
        tick();
        ifc.wr_en   = 1'b0;
    endtask

    // One full sweep; returns in IDLE one cycle after the done pulse.
    task automatic sweep();
        int n;
        n = 0;
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        while (ifc.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.done !== 1'b1) chk("sweep_done_timeout", ifc.done, 1);
        tick();
    endtask

    task automatic chk_st(input string tag, input int a, input int exp);
        ifc.rd_addr = 2'(a);
        tick();
        chk(tag, ifc.rd_state, exp);
    endtask

    initial begin
        total = 0;
        bad = 0;
        done_cnt = 0;
        reset = 1'b1;
        ifc.step = 1'b0;
        ifc.wr_en = 1'b0;
        ifc.wr_addr = '0;
        ifc.wr_data = '0;
        ifc.rd_addr = '0;
        tick();
        tick();
        // Reset state while reset is held.
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_spike_vec", ifc.spike_vec, 0);
        chk("rst_spike_cnt", ifc.spike_cnt, 0);
        chk("rst_overrun", ifc.overrun, 0);
        chk("rst_rd_state", ifc.rd_state, 0);
        reset = 1'b0;
        tick();

        // Sweep timing: busy in cycles t+1..t+5, done only in t+5.
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("lat_busy_c%0d", c), ifc.busy, (c <= 5) ? 1 : 0);
            chk($sformatf("lat_done_c%0d", c), ifc.done, (c == 5) ? 1 : 0);
            tick();
        end
        chk("lat_no_overrun", ifc.overrun, 0);

        // Second step at t+2 is dropped and flagged; one done at t+5.
        d0 = done_cnt;
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        tick();
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        chk("ovr_flag", ifc.overrun, 1);
        chk("ovr_busy_t3", ifc.busy, 1);
        tick();
        chk("ovr_done_t4", ifc.done, 0);
        tick();
        chk("ovr_done_t5", ifc.done, 1);
        tick();
        chk("ovr_busy_t6", ifc.busy, 0);
        for (int c = 0; c < 8; c++) tick();
        chk("ovr_one_done", done_cnt - d0, 1);
        chk("ovr_sticky", ifc.overrun, 1);
        do_reset();
        chk("ovr_cleared_by_reset", ifc.overrun, 0);

        // cur[0]=120: st[0] 120,180,210,120; spike on the fourth sweep only.
        wr(0, 120);
        for (int s = 0; s < 4; s++) begin
            sweep();
            chk($sformatf("lif0_st_s%0d", s + 1), ifc.spike_vec, exp_sv[s]);
            chk($sformatf("lif0_cnt_s%0d", s + 1), ifc.spike_cnt, exp_cnt[s]);
            chk_st($sformatf("lif0_state_s%0d", s + 1), 0, exp_st[s]);
        end

        // cur[1]=180: 180, 270 clipped to 255, then spike and reset to 180.
        do_reset();
        wr(1, 180);
        sweep();
        chk_st("sat_s1", 1, 180);
        sweep();
        chk_st("sat_s2_clip", 1, 255);
        chk("sat_s2_vec", ifc.spike_vec, 0);
        sweep();
        chk("sat_s3_vec", ifc.spike_vec, 4'b0010);
        chk_st("sat_s3_state", 1, 180);

        // Write to cur[2] during its own update cycle: old value used this sweep.
        do_reset();
        wr(2, 10);
        sweep();
        chk_st("wr_s1", 2, 10);
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        tick();
        tick();
        chk("wr_in_update", ifc.busy, 1);
        wr(2, 50);
        for (int c = 0; c < 4; c++) tick();
        chk_st("wr_s2_old_cur", 2, 15);
        ifc.rd_addr = 2'd2;
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        tick();
        tick();
        chk("rd_before_update", ifc.rd_state, 15);
        tick();
        tick();
        chk("rd_done_cycle", ifc.done, 1);
        chk("rd_after_update", ifc.rd_state, 57);
        tick();

        // Reset in cycle t+3 aborts the sweep without a done pulse.
        do_reset();
        wr(0, 255);
        sweep();
        sweep();
        chk("abort_pre_cnt", ifc.spike_cnt, 1);
        chk("abort_pre_vec", ifc.spike_vec, 4'b0001);
        d0 = done_cnt;
        ifc.rd_addr = 2'd0;
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_vec", ifc.spike_vec, 0);
        chk("abort_cnt", ifc.spike_cnt, 0);
        chk("abort_rd", ifc.rd_state, 0);
        chk("abort_overrun", ifc.overrun, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk_st("abort_st0_cleared", 0, 0);
        wr(3, 100);
        d0 = done_cnt;
        sweep();
        chk("abort_next_done", done_cnt - d0, 1);
        chk_st("abort_next_st3", 3, 100);

        // All currents 255: four spikes per sweep from sweep 2, saturating at 255.
        do_reset();
        for (int a = 0; a < N; a++) wr(a, 255);
        for (int s = 1; s <= 600; s++) begin
            sweep();
            if (s == 1)  chk("cnt_s1", ifc.spike_cnt, 0);
            if (s == 2)  chk("cnt_s2", ifc.spike_cnt, 4);
            if (s == 64) chk("cnt_s64", ifc.spike_cnt, 252);
            if (s == 65) chk("cnt_s65_sat", ifc.spike_cnt, 255);
        end
        chk("cnt_s600", ifc.spike_cnt, 255);
        chk("vec_s600", ifc.spike_vec, 4'b1111);
        chk_st("st_s600", 3, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
